// File: rtl/iso_pkg.sv
// Shared definitions for the isochronous idle-pattern path.
//   K_BS / K_SR / DUMMY_SYM : symbol bytes emitted by the idle generator
//   idle_state_e            : idle generator FSM states
package iso_pkg;

    localparam logic [7:0] K_BS      = 8'hBC;  // K28.5 blanking start
    localparam logic [7:0] K_SR      = 8'h1C;  // K28.0 scrambler reset
    localparam logic [7:0] DUMMY_SYM = 8'h00;

    typedef enum logic [2:0] {
        OFF,
        BS,
        VBID,
        MVID,
        MAUD,
        DUMMY
    } idle_state_e;

endpackage

// File: rtl/iso_idle_pattern_gen_if.sv
// Scheduler <-> idle-pattern-generator lane interface.
//   sched_idle_en     : scheduler request to drive the idle pattern (level)
//   idle_sym/idle_k   : idle symbol byte and K-code flag
//   idle_vld          : symbol valid this cycle
//   idle_activate_en  : pulse on the last symbol of each idle period
// Modports: master = scheduler side, slave = generator side.
interface iso_idle_pattern_gen_if;

    logic       sched_idle_en;
    logic [7:0] idle_sym;
    logic       idle_k;
    logic       idle_vld;
    logic       idle_activate_en;

    modport master (
        output sched_idle_en,
        input  idle_sym,
        input  idle_k,
        input  idle_vld,
        input  idle_activate_en
    );

    modport slave (
        input  sched_idle_en,
        output idle_sym,
        output idle_k,
        output idle_vld,
        output idle_activate_en
    );

endinterface

// File: rtl/iso_idle_pattern_gen.sv
// Per-lane DisplayPort idle-pattern generator. While requested by the scheduler it emits
// BS, VB-ID, Mvid, Maud and then dummy 0x00 symbols, repeating every IDLE_PERIOD symbols,
// one symbol per clock. A period that has started always completes; idle_activate_en marks
// its last symbol so the scheduler can switch the lane back to stream.
//
// Ports:
//   clk    : symbol clock
//   rst_n  : asynchronous active-low reset
//   bus    : iso_idle_pattern_gen_if.slave (sched_idle_en in; idle_sym, idle_k, idle_vld,
//            idle_activate_en out, all registered)
//
// Build option: define ISO_IDLE_SR_EN to replace every SR_INTERVAL-th BS (starting with the
// first one after OFF) by SR so the lane scrambler is re-seeded.
module iso_idle_pattern_gen
    import iso_pkg::*;
#(
    parameter int unsigned IDLE_PERIOD = 8192,
    parameter logic [7:0]  VBID_IDLE   = 8'h09,
    parameter int unsigned SR_INTERVAL = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    iso_idle_pattern_gen_if.slave   bus
);

    if (IDLE_PERIOD < 8 || IDLE_PERIOD > 8192) begin : g_bad_period
        $error("iso_idle_pattern_gen: IDLE_PERIOD must be in 8..8192");
    end

    if (SR_INTERVAL < 1 || SR_INTERVAL > 512) begin : g_bad_sr_interval
        $error("iso_idle_pattern_gen: SR_INTERVAL must be in 1..512");
    end

    localparam logic [12:0] LAST_SYM = 13'(IDLE_PERIOD - 1);

    idle_state_e state_q, state_d;
    logic [12:0] sym_cnt_q, sym_cnt_d;

    logic [7:0]  idle_sym_q, idle_sym_d;
    logic        idle_k_q, idle_k_d;
    logic        idle_vld_q, idle_vld_d;
    logic        idle_act_q, idle_act_d;

    logic        is_sr;

    // state_q / sym_cnt_q describe the symbol currently on the outputs
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        unique case (state_q)
            OFF: begin
                if (bus.sched_idle_en) begin
                    state_d   = BS;
                    sym_cnt_d = '0;
                end
            end
            default: begin
                if (sym_cnt_q == LAST_SYM) begin
                    // Period boundary is the only place the request is honoured
                    state_d   = bus.sched_idle_en ? BS : OFF;
                    sym_cnt_d = '0;
                end else begin
                    sym_cnt_d = sym_cnt_q + 13'd1;
                    case (state_q)
                        BS:      state_d = VBID;
                        VBID:    state_d = MVID;
                        MVID:    state_d = MAUD;
                        default: state_d = DUMMY;
                    endcase
                end
            end
        endcase
    end

`ifdef ISO_IDLE_SR_EN
    localparam logic [8:0] SR_LAST = 9'(SR_INTERVAL - 1);

    logic [8:0] bs_cnt_q, bs_cnt_d;

    // Entering from OFF preloads the SR slot so the first BS after OFF is an SR
    always_comb begin
        bs_cnt_d = bs_cnt_q;
        if (state_d == OFF) begin
            bs_cnt_d = '0;
        end else if (state_d == BS) begin
            if (state_q == OFF) begin
                bs_cnt_d = SR_LAST;
            end else if (bs_cnt_q == SR_LAST) begin
                bs_cnt_d = '0;
            end else begin
                bs_cnt_d = bs_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_cnt_q <= '0;
        end else begin
            bs_cnt_q <= bs_cnt_d;
        end
    end

    assign is_sr = (bs_cnt_d == SR_LAST);
`else
    assign is_sr = 1'b0;
`endif

    // Outputs are decoded from the next state and registered alongside it
    always_comb begin
        idle_sym_d = DUMMY_SYM;
        idle_k_d   = 1'b0;
        idle_vld_d = (state_d != OFF);
        idle_act_d = (state_d != OFF) && (sym_cnt_d == LAST_SYM);
        case (state_d)
            BS: begin
                idle_sym_d = is_sr ? K_SR : K_BS;
                idle_k_d   = 1'b1;
            end
            VBID:    idle_sym_d = VBID_IDLE;
            default: idle_sym_d = DUMMY_SYM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            sym_cnt_q  <= '0;
            idle_sym_q <= '0;
            idle_k_q   <= 1'b0;
            idle_vld_q <= 1'b0;
            idle_act_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            idle_sym_q <= idle_sym_d;
            idle_k_q   <= idle_k_d;
            idle_vld_q <= idle_vld_d;
            idle_act_q <= idle_act_d;
        end
    end

    assign bus.idle_sym         = idle_sym_q;
    assign bus.idle_k           = idle_k_q;
    assign bus.idle_vld         = idle_vld_q;
    assign bus.idle_activate_en = idle_act_q;

endmodule

// File: tb/tb_iso_idle_pattern_gen.sv
// Bench for iso_idle_pattern_gen: directed scenarios plus randomized request toggling,
// every output symbol compared against a position-in-period reference model.
module tb_iso_idle_pattern_gen;

    localparam int          PERIOD = 16;
    localparam int          SR_INT = 4;
    localparam logic [7:0]  VBID   = 8'h09;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iso_idle_pattern_gen_if bus ();

    iso_idle_pattern_gen #(
        .IDLE_PERIOD (PERIOD),
        .VBID_IDLE   (VBID),
        .SR_INTERVAL (SR_INT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: is a period running, position within it, BS count since OFF
    bit m_active = 1'b0;
    int m_pos    = 0;
    int m_nbs    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_nbs    = 0;
    endtask

    task automatic model_clock(input bit en);
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_nbs    = 0;
            end
        end else if (m_pos == PERIOD - 1) begin
            if (en) begin
                m_pos = 0;
                m_nbs++;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] e_sym;
        logic       e_k;
        logic       e_vld;
        logic       e_act;
        e_vld = m_active;
        e_k   = m_active && (m_pos == 0);
        e_act = m_active && (m_pos == PERIOD - 1);
        e_sym = 8'h00;
        if (m_active && m_pos == 0) begin
            e_sym = 8'hBC;
`ifdef ISO_IDLE_SR_EN
            if (m_nbs % SR_INT == 0) e_sym = 8'h1C;
`endif
        end else if (m_active && m_pos == 1) begin
            e_sym = VBID;
        end
        check({tag, ".vld"}, 32'(bus.idle_vld), 32'(e_vld));
        check({tag, ".k"},   32'(bus.idle_k),   32'(e_k));
        check({tag, ".act"}, 32'(bus.idle_activate_en), 32'(e_act));
        check({tag, ".sym"}, 32'(bus.idle_sym), 32'(e_sym));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock(bus.sched_idle_en);
        #1;
        check_outputs(tag);
    endtask

    task automatic wait_pos(input int pos, input string tag);
        int n = 0;
        while (!(m_active && m_pos == pos) && n < 3 * PERIOD) begin
            step(tag);
            n++;
        end
        check({tag, ".reach"}, 32'(m_active && m_pos == pos), 32'd1);
    endtask

    initial begin
        bus.sched_idle_en = 1'b1;
        rst_n = 1'b0;
        model_reset();

        // Reset held with request high: everything stays at 0
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release");

        // Continuous request: several full periods incl. wraps and SR spacing
        repeat (39) step("hold");
        repeat (5 * PERIOD) step("hold_long");

        // Drop request mid-period: period completes, then OFF
        wait_pos(5, "drop_wait");
        bus.sched_idle_en = 1'b0;
        repeat (PERIOD) step("drop");

        // Drop then re-raise within the tail: no OFF gap
        bus.sched_idle_en = 1'b1;
        step("reraise_start");
        wait_pos(5, "reraise_w5");
        bus.sched_idle_en = 1'b0;
        wait_pos(10, "reraise_w10");
        bus.sched_idle_en = 1'b1;
        repeat (PERIOD + 4) step("reraise");

        // Random request toggling
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) bus.sched_idle_en = ~bus.sched_idle_en;
            step("rand");
        end

        // Asynchronous reset mid-period
        bus.sched_idle_en = 1'b1;
        wait_pos(7, "areset_wait");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("areset_now");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("areset_hold");
        end
        @(negedge clk);
        bus.sched_idle_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) step("areset_idle");
        bus.sched_idle_en = 1'b1;
        repeat (PERIOD + 2) step("areset_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
